// File: rtl/crc_encode_serial_pkg.sv
// Shared constants, FSM encoding and width helper for the serial CRC encoder.
// Default generator x^6+x^5+x^4+x^3+x+1 gives a 6-bit remainder.
package crc_encode_serial_pkg;

  localparam int         CRC_N   = 16;
  localparam int         CRC_R   = 7;
  localparam logic [6:0] CRC_DIV = 7'b1111011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } crc_state_e;

  // Smallest width able to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_encode_serial_if.sv
// Data-in and codeword-out channels of the serial CRC encoder.
// Both channels: a transfer happens on a rising edge where valid && ready; the source holds its payload stable until then.
interface crc_encode_serial_if
  import crc_encode_serial_pkg::*;
#(
  parameter int N = CRC_N,
  parameter int R = CRC_R
) ();

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     data_in;
  logic             out_valid;
  logic             out_ready;
  logic [N+R-2:0]   codeword;
  logic             busy;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, codeword, busy
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, codeword, busy
  );

endinterface

// File: rtl/crc_encode_serial_lfsr_step.sv
// One bit of MSB-first polynomial division: feeds data bit d into remainder rem.
// Kept standalone so a serial checker can reuse the same update.
module crc_lfsr_step
  import crc_encode_serial_pkg::*;
#(
  parameter int         R   = CRC_R,
  parameter logic [R-1:0] DIV = CRC_DIV
) (
  input  logic [R-2:0] rem_i,
  input  logic         d_i,
  output logic [R-2:0] rem_o
);

  logic fb;

  // DIV[R-1] is the implicit leading term cancelled by the feedback.
  assign fb    = rem_i[R-2] ^ d_i;
  assign rem_o = {rem_i[R-3:0], 1'b0} ^ (fb ? DIV[R-2:0] : {(R-1){1'b0}});

endmodule

// File: rtl/crc_encode_serial.sv
// Bit-serial CRC encoder: accepts an N-bit word, divides it MSB-first over N cycles,
// then presents {data, remainder} until the downstream takes it.
module crc_encode_serial
  import crc_encode_serial_pkg::*;
#(
  parameter int           N   = CRC_N,
  parameter int           R   = CRC_R,
  parameter logic [R-1:0] DIV = CRC_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  crc_encode_serial_if.slave    bus,
  output crc_state_e            state_o
);

  localparam int CNT_W = clog2(N);

  crc_state_e       state_q;
  logic [N-1:0]     data_q;
  logic [N-1:0]     shift_q;
  logic [R-2:0]     rem_q;
  logic [R-2:0]     rem_d;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic [N+R-2:0]   codeword_q;

  crc_lfsr_step #(
    .R   (R),
    .DIV (DIV)
  ) u_step (
    .rem_i (rem_q),
    .d_i   (shift_q[N-1]),
    .rem_o (rem_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      shift_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      codeword_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            data_q     <= bus.data_in;
            shift_q    <= bus.data_in;
            rem_q      <= '0;
            cnt_q      <= CNT_W'(N - 1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          rem_q   <= rem_d;
          shift_q <= {shift_q[N-2:0], 1'b0};
          // The codeword is captured from the final step so it is ready on DONE entry.
          if (cnt_q == '0) begin
            codeword_q  <= {data_q, rem_d};
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            codeword_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          codeword_q  <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.codeword  = codeword_q;
  assign bus.busy      = busy_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_crc_encode_serial.sv
// Bench for crc_encode_serial: directed vectors, backpressure, resets and a random soak
// checked against a long-division reference and a codeword checker.
module tb_crc_encode_serial;
  import crc_encode_serial_pkg::*;

  localparam int             N      = 16;
  localparam int             R      = 7;
  localparam int             CW     = N + R - 1;
  localparam logic [R-1:0]   DIV_TB = 7'b1111011;
  localparam int             WORDS  = 1000;

  logic       clk = 1'b0;
  logic       rst;
  crc_state_e state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [CW-1:0] exp_q[$];

  crc_encode_serial_if #(.N(N), .R(R)) bus ();

  crc_encode_serial #(.N(N), .R(R), .DIV(DIV_TB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [R-2:0] div_rem(input logic [CW-1:0] cw);
    logic [CW-1:0] r;
    r = cw;
    for (int i = CW - 1; i >= R - 1; i--) begin
      if (r[i]) r = r ^ (CW'(DIV_TB) << (i - (R - 1)));
    end
    return r[R-2:0];
  endfunction

  function automatic logic [CW-1:0] expected_cw(input logic [N-1:0] d);
    return {d, div_rem({d, {(R-1){1'b0}}})};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_word(input logic [N-1:0] d, output bit ok);
    int waitc;
    waitc = 0;
    ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    while (!bus.in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (bus.in_ready) begin
      ok = 1'b1;
      exp_q.push_back(expected_cw(d));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [CW-1:0] cw, output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    cw  = '0;
    while (lat < 200) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        cw = bus.codeword;
        break;
      end
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [CW-1:0] cw;
    logic [CW-1:0] exp;
    int lat;
    bit ok;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.codeword !== '0 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b1 || state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_values: got ov=%b cw=%h busy=%b ir=%b st=%0d, expected 0 0 0 1 0",
               bus.out_valid, bus.codeword, bus.busy, bus.in_ready, state);
    end
    rst = 1'b0;
    bus.out_ready = 1'b0;
    send_word(16'h1234, ok);
    repeat (20) @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pre_done: got out_valid=%b expected 1", bus.out_valid);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.codeword !== '0 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b1 || state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_async_done: got ov=%b cw=%h busy=%b ir=%b st=%0d, expected 0 0 0 1 0",
               bus.out_valid, bus.codeword, bus.busy, bus.in_ready, state);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send_word(16'h0001, ok);
    wait_out(cw, lat, ok);
    exp = exp_q.pop_front();
    tests_run++;
    if (!ok || cw !== 22'h00007B || cw !== exp) begin
      tests_failed++;
      $display("FAIL reset_clean_word: got %h expected 00007b (model %h)", cw, exp);
    end
  endtask

  task automatic test_known_vectors();
    logic [N-1:0]  din [4];
    logic [CW-1:0] want[4];
    logic [CW-1:0] cw;
    logic [CW-1:0] cwf;
    logic [CW-1:0] exp;
    int lat;
    bit ok;
    din[0] = 16'h0001; want[0] = 22'h00007B;
    din[1] = 16'h0002; want[1] = 22'h00008D;
    din[2] = 16'h0003; want[2] = 22'h0000F6;
    din[3] = 16'h0000; want[3] = 22'h000000;
    bus.out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send_word(din[v], ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL known_accept[%0d]: in_ready never seen", v);
      end
      wait_out(cw, lat, ok);
      exp = exp_q.pop_front();
      tests_run++;
      if (!ok || lat !== N) begin
        tests_failed++;
        $display("FAIL known_latency[%0d]: got %0d cycles expected %0d", v, lat, N);
      end
      tests_run++;
      if (cw !== want[v] || cw !== exp) begin
        tests_failed++;
        $display("FAIL known_codeword[%0d]: got %h expected %h", v, cw, want[v]);
      end
      tests_run++;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || state !== ST_DONE) begin
        tests_failed++;
        $display("FAIL known_done_flags[%0d]: got busy=%b ir=%b st=%0d expected 1 0 2",
                 v, bus.busy, bus.in_ready, state);
      end
      tests_run++;
      if (div_rem(cw) !== '0) begin
        tests_failed++;
        $display("FAIL known_checker[%0d]: got syndrome %h expected 0", v, div_rem(cw));
      end
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.codeword !== '0 || state !== ST_IDLE) begin
        tests_failed++;
        $display("FAIL known_one_cycle_done[%0d]: got ov=%b ir=%b cw=%h st=%0d expected 0 1 0 0",
                 v, bus.out_valid, bus.in_ready, bus.codeword, state);
      end
      if (v == 0) begin
        for (int b = 0; b < CW; b++) begin
          cwf = cw;
          cwf[b] = ~cwf[b];
          tests_run++;
          if (div_rem(cwf) === '0) begin
            tests_failed++;
            $display("FAIL known_flip_bit[%0d]: got syndrome 0 expected nonzero", b);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] cw;
    logic [CW-1:0] exp;
    int lat;
    bit ok;
    bus.out_ready = 1'b0;
    send_word(16'hBEEF, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.data_in  = 16'hFFFF;
      tests_run++;
      if (bus.in_ready !== 1'b0 || state !== ST_SHIFT) begin
        tests_failed++;
        $display("FAIL bp_shift_ready[%0d]: got ir=%b st=%0d expected 0 1", i, bus.in_ready, state);
      end
    end
    bus.in_valid = 1'b0;
    wait_out(cw, lat, ok);
    exp = exp_q.pop_front();
    tests_run++;
    if (!ok || cw !== exp) begin
      tests_failed++;
      $display("FAIL bp_codeword: got %h expected %h", cw, exp);
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.data_in  = 16'($urandom_range(0, 65535));
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.codeword !== exp || bus.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got ov=%b cw=%h ir=%b expected 1 %h 0",
                 i, bus.out_valid, bus.codeword, bus.in_ready, exp);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL bp_release: got ov=%b ir=%b st=%0d expected 0 1 0",
               bus.out_valid, bus.in_ready, state);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL bp_no_ghost_word: got busy=%b st=%0d expected 0 0", bus.busy, state);
    end
  endtask

  task automatic test_mid_shift_reset();
    logic [CW-1:0] cw;
    logic [CW-1:0] exp;
    int lat;
    bit ok;
    bus.out_ready = 1'b1;
    send_word(16'hA5A5, ok);
    repeat (7) @(posedge clk);
    #1;
    tests_run++;
    if (bus.busy !== 1'b1 || state !== ST_SHIFT) begin
      tests_failed++;
      $display("FAIL mid_reset_pre: got busy=%b st=%0d expected 1 1", bus.busy, state);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.codeword !== '0 || bus.busy !== 1'b0 ||
        bus.in_ready !== 1'b1 || state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL mid_reset_values: got ov=%b cw=%h busy=%b ir=%b st=%0d expected 0 0 0 1 0",
               bus.out_valid, bus.codeword, bus.busy, bus.in_ready, state);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send_word(16'h0002, ok);
    wait_out(cw, lat, ok);
    exp = exp_q.pop_front();
    tests_run++;
    if (!ok || lat !== N || cw !== 22'h00008D || cw !== exp) begin
      tests_failed++;
      $display("FAIL mid_reset_fresh: got %h after %0d cycles expected 00008d after %0d", cw, lat, N);
    end
    @(negedge clk);
  endtask

  task automatic test_soak();
    fork
      begin : producer
        bit ok;
        for (int i = 0; i < WORDS; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send_word(16'($urandom_range(0, 65535)), ok);
          if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL soak_accept[%0d]: in_ready never seen", i);
            break;
          end
        end
      end
      begin : consumer
        int got;
        int stall;
        int b;
        logic [CW-1:0] cw;
        logic [CW-1:0] cwf;
        logic [CW-1:0] exp;
        got = 0;
        stall = 0;
        while (got < WORDS && stall < 500) begin
          @(negedge clk);
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid && bus.out_ready) begin
            cw = bus.codeword;
            tests_run++;
            if (exp_q.size() == 0) begin
              tests_failed++;
              $display("FAIL soak_unexpected[%0d]: got %h with nothing expected", got, cw);
            end else begin
              exp = exp_q.pop_front();
              if (cw !== exp) begin
                tests_failed++;
                $display("FAIL soak_codeword[%0d]: got %h expected %h", got, cw, exp);
              end
              tests_run++;
              if (div_rem(cw) !== '0 || cw[CW-1:R-1] !== exp[CW-1:R-1]) begin
                tests_failed++;
                $display("FAIL soak_checker[%0d]: got syndrome %h data %h expected 0 %h",
                         got, div_rem(cw), cw[CW-1:R-1], exp[CW-1:R-1]);
              end
            end
            b = $urandom_range(0, CW - 1);
            cwf = cw;
            cwf[b] = ~cwf[b];
            tests_run++;
            if (div_rem(cwf) === '0) begin
              tests_failed++;
              $display("FAIL soak_flip[%0d]: bit %0d flipped got syndrome 0 expected nonzero", got, b);
            end
            got++;
            stall = 0;
          end else begin
            stall++;
          end
        end
        tests_run++;
        if (got !== WORDS) begin
          tests_failed++;
          $display("FAIL soak_count: got %0d codewords expected %0d", got, WORDS);
        end
      end
    join
    bus.out_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_mid_shift_reset();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #5_000_000;
    tests_run++;
    tests_failed++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
